gate_array_regs: RTL and testbench

GATE_ARRAY_REGS -- requirements
Module: gate_array_regs

---
 rtl/gate_array_if.sv | 18 +
 rtl/gate_array_regs.sv | 155 +++++++++++++++
 tb/tb_gate_array_regs.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/gate_array_if.sv
// ============================================================================
// Module  : gate_array_if
// Purpose : CPU-side I/O bus between the address decoder and the gate array.
// Rev     : 1.0
// ============================================================================
`default_nettype none

interface gate_array_if;
    logic       io_wr;
    logic [7:0] io_data;
    logic       int_ack;
    logic       n_int;

    modport master (output io_wr, output io_data, output int_ack, input  n_int);
    modport slave  (input  io_wr, input  io_data, input  int_ack, output n_int);
endinterface

`default_nettype wire

// File: rtl/gate_array_regs.sv
// ============================================================================
// Module  : gate_array_regs
// Purpose : Gate-array palette, mode/ROM control and raster interrupt counter.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module gate_array_regs (
    input  wire logic        clk,
    input  wire logic        reset,
    gate_array_if.slave      cpu,
    input  wire logic [3:0]  pen,
    input  wire logic        hsync_n,
    input  wire logic        vsync_n,
    output logic      [1:0]  mode,
    output logic      [4:0]  border_color,
    output logic      [4:0]  color,
    output logic             rom_lo_en,
    output logic             rom_hi_en
);

    localparam logic [1:0] c_CMD_PEN  = 2'b00;
    localparam logic [1:0] c_CMD_INK  = 2'b01;
    localparam logic [1:0] c_CMD_CTRL = 2'b10;
    localparam logic [5:0] c_LAST_LINE = 6'd51;

    logic [4:0] r_pen_sel;
    logic [4:0] r_ink [16];
    logic [4:0] r_border;
    logic [1:0] r_mode_pend;
    logic [1:0] r_mode;
    logic [5:0] r_line_cnt;
    logic [1:0] r_vs_dly;
    logic       r_prev_hs;
    logic       r_prev_vs;
    logic       r_int_n;
    logic       r_rom_lo;
    logic       r_rom_hi;

    logic       w_hs_start;
    logic       w_hs_end;
    logic       w_vs_start;
    logic       w_vs_fire;
    logic       w_wr_clr;
    logic [1:0] w_cmd;
    logic [5:0] w_cnt_nxt;
    logic       w_int_nxt;
    logic [1:0] w_vs_dly_nxt;

    assign w_cmd      = cpu.io_data[7:6];
    assign w_hs_start =  r_prev_hs & ~hsync_n;
    assign w_hs_end   = ~r_prev_hs &  hsync_n;
    assign w_vs_start =  r_prev_vs & ~vsync_n;
    assign w_wr_clr   = cpu.io_wr & (w_cmd == c_CMD_CTRL) & cpu.io_data[4];
    // A fresh vsync start reloads the delay, so it suppresses a same-cycle expiry.
    assign w_vs_fire  = w_hs_end & (r_vs_dly == 2'd1) & ~w_vs_start;

    // Int-set decisions use the pre-ack counter so a same-cycle set beats int_ack.
    always_comb begin
        w_cnt_nxt    = r_line_cnt;
        w_int_nxt    = ~r_int_n;
        w_vs_dly_nxt = r_vs_dly;

        if (cpu.int_ack) begin
            w_int_nxt    = 1'b0;
            w_cnt_nxt[5] = 1'b0;
        end

        if (w_vs_start) begin
            w_vs_dly_nxt = 2'd2;
        end else if (w_hs_end && (r_vs_dly != 2'd0)) begin
            w_vs_dly_nxt = r_vs_dly - 2'd1;
        end

        if (w_vs_fire) begin
            if (r_line_cnt[5]) begin
                w_int_nxt = 1'b1;
            end
            w_cnt_nxt = 6'd0;
        end else if (w_hs_end) begin
            if (r_line_cnt == c_LAST_LINE) begin
                w_cnt_nxt = 6'd0;
                w_int_nxt = 1'b1;
            end else begin
                w_cnt_nxt = w_cnt_nxt + 6'd1;
            end
        end

        if (w_wr_clr) begin
            w_cnt_nxt = 6'd0;
            w_int_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pen_sel   <= 5'd0;
            for (int i = 0; i < 16; i++) begin
                r_ink[i] <= 5'd0;
            end
            r_border    <= 5'd0;
            r_mode_pend <= 2'b01;
            r_mode      <= 2'b01;
            r_line_cnt  <= 6'd0;
            r_vs_dly    <= 2'd0;
            r_prev_hs   <= 1'b1;
            r_prev_vs   <= 1'b1;
            r_int_n     <= 1'b1;
            r_rom_lo    <= 1'b1;
            r_rom_hi    <= 1'b1;
        end else begin
            r_prev_hs  <= hsync_n;
            r_prev_vs  <= vsync_n;
            r_line_cnt <= w_cnt_nxt;
            r_vs_dly   <= w_vs_dly_nxt;
            r_int_n    <= ~w_int_nxt;

            if (w_hs_start) begin
                r_mode <= r_mode_pend;
            end

            if (cpu.io_wr) begin
                case (w_cmd)
                    c_CMD_PEN: begin
                        r_pen_sel <= cpu.io_data[4] ? 5'b10000 : cpu.io_data[4:0];
                    end
                    c_CMD_INK: begin
                        if (r_pen_sel[4]) begin
                            r_border <= cpu.io_data[4:0];
                        end else begin
                            r_ink[r_pen_sel[3:0]] <= cpu.io_data[4:0];
                        end
                    end
                    c_CMD_CTRL: begin
                        r_mode_pend <= cpu.io_data[1:0];
                        r_rom_lo    <= ~cpu.io_data[2];
                        r_rom_hi    <= ~cpu.io_data[3];
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign mode         = r_mode;
    assign border_color = r_border;
    assign color        = r_ink[pen];
    assign rom_lo_en    = r_rom_lo;
    assign rom_hi_en    = r_rom_hi;
    assign cpu.n_int    = r_int_n;

endmodule

`default_nettype wire

// File: tb/tb_gate_array_regs.sv
// ============================================================================
// Module  : tb_gate_array_regs
// Purpose : Randomised scoreboard bench for gate_array_regs against a behavioural model.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module tb_gate_array_regs;

    logic       clk;
    logic       reset;
    logic [3:0] pen;
    logic       hsync_n;
    logic       vsync_n;
    logic [1:0] mode;
    logic [4:0] border_color;
    logic [4:0] color;
    logic       rom_lo_en;
    logic       rom_hi_en;

    gate_array_if cpu_if ();

    gate_array_regs dut (
        .clk          (clk),
        .reset        (reset),
        .cpu          (cpu_if),
        .pen          (pen),
        .hsync_n      (hsync_n),
        .vsync_n      (vsync_n),
        .mode         (mode),
        .border_color (border_color),
        .color        (color),
        .rom_lo_en    (rom_lo_en),
        .rom_hi_en    (rom_hi_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int mode;
        int border;
        int color;
        int rom_lo;
        int rom_hi;
        int n_int;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Behavioural model: the chip's visible state as plain integers.
    int m_ink[16];
    int m_border, m_pen_sel, m_pend, m_mode, m_line, m_vdelay;
    int m_prev_hs, m_prev_vs, m_int, m_rom_lo, m_rom_hi;

    function automatic void model_reset();
        for (int i = 0; i < 16; i++) m_ink[i] = 0;
        m_border = 0; m_pen_sel = 0; m_pend = 1; m_mode = 1;
        m_line = 0; m_vdelay = 0; m_prev_hs = 1; m_prev_vs = 1;
        m_int = 0; m_rom_lo = 1; m_rom_hi = 1;
    endfunction

    function automatic void model_clock(int wr, int d, int hs, int vs, int ack);
        int hs_start, hs_end, vs_start, line, intf, cmd;
        hs_start = (m_prev_hs == 1 && hs == 0);
        hs_end   = (m_prev_hs == 0 && hs == 1);
        vs_start = (m_prev_vs == 1 && vs == 0);
        cmd      = d / 64;
        line = m_line;
        intf = m_int;
        if (ack) begin
            intf = 0;
            line = line % 32;
        end
        if (hs_end && m_vdelay == 1 && !vs_start) begin
            if (m_line >= 32) intf = 1;
            line = 0;
        end else if (hs_end) begin
            if (m_line + 1 == 52) begin
                line = 0;
                intf = 1;
            end else begin
                line = line + 1;
            end
        end
        if (vs_start) m_vdelay = 2;
        else if (hs_end && m_vdelay > 0) m_vdelay = m_vdelay - 1;
        if (hs_start) m_mode = m_pend;
        if (wr) begin
            if (cmd == 0) begin
                m_pen_sel = ((d & 16) != 0) ? 16 : (d % 32);
            end else if (cmd == 1) begin
                if (m_pen_sel >= 16) m_border = d % 32;
                else m_ink[m_pen_sel] = d % 32;
            end else if (cmd == 2) begin
                m_pend   = d % 4;
                m_rom_lo = ((d & 4) != 0) ? 0 : 1;
                m_rom_hi = ((d & 8) != 0) ? 0 : 1;
                if ((d & 16) != 0) begin
                    line = 0;
                    intf = 0;
                end
            end
        end
        m_line    = line;
        m_int     = intf;
        m_prev_hs = hs;
        m_prev_vs = vs;
    endfunction

    function automatic exp_t model_out(int p);
        exp_t e;
        e.mode   = m_mode;
        e.border = m_border;
        e.color  = m_ink[p];
        e.rom_lo = m_rom_lo;
        e.rom_hi = m_rom_hi;
        e.n_int  = m_int ? 0 : 1;
        return e;
    endfunction

    // One clock of stimulus: drive at the falling edge, predict the post-edge outputs.
    task automatic step(input int rst, input int wr, input int d, input int p,
                        input int hs, input int vs, input int ack);
        @(negedge clk);
        reset          = rst[0];
        cpu_if.io_wr   = wr[0];
        cpu_if.io_data = d[7:0];
        cpu_if.int_ack = ack[0];
        pen            = p[3:0];
        hsync_n        = hs[0];
        vsync_n        = vs[0];
        if (rst) model_reset();
        else     model_clock(wr, d, hs, vs, ack);
        q.push_back(model_out(p));
    endtask

    int cur_pen = 3;

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, cur_pen, 1, 1, 0);
    endtask

    task automatic wr(input int d);
        step(0, 1, d, cur_pen, 1, 1, 0);
    endtask

    task automatic hline(input int n);
        for (int i = 0; i < n; i++) begin
            step(0, 0, 0, cur_pen, 0, 1, 0);
            step(0, 0, 0, cur_pen, 0, 1, 0);
            step(0, 0, 0, cur_pen, 1, 1, 0);
            step(0, 0, 0, cur_pen, 1, 1, 0);
        end
    endtask

    task automatic ack_pulse();
        step(0, 0, 0, cur_pen, 1, 1, 1);
        idle(1);
    endtask

    task automatic vsync_start();
        step(0, 0, 0, cur_pen, 1, 0, 0);
        step(0, 0, 0, cur_pen, 1, 1, 0);
    endtask

    task automatic do_reset();
        step(1, 0, 0, cur_pen, 1, 1, 0);
        step(1, 0, 0, cur_pen, 1, 1, 0);
        idle(1);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("mode",         int'(mode),         e.mode);
            chk("border_color", int'(border_color), e.border);
            chk("color",        int'(color),        e.color);
            chk("rom_lo_en",    int'(rom_lo_en),    e.rom_lo);
            chk("rom_hi_en",    int'(rom_hi_en),    e.rom_hi);
            chk("n_int",        int'(cpu_if.n_int), e.n_int);
        end
    end

    initial begin
        int hs_level, hs_left, vs_left;
        reset = 1'b0; pen = 4'd3; hsync_n = 1'b1; vsync_n = 1'b1;
        cpu_if.io_wr = 1'b0; cpu_if.io_data = 8'd0; cpu_if.int_ack = 1'b0;
        model_reset();
        do_reset();

        // Palette: pen 3 gets 0x0C, other pens stay clear.
        wr(8'h03); wr(8'h4C); idle(1);
        cur_pen = 2; idle(1); cur_pen = 3; idle(1);
        // Border select ignores low bits; ink[0] untouched.
        wr(8'h10); wr(8'h54); cur_pen = 0; idle(2); cur_pen = 3;
        // Mode change waits for hsync start.
        wr(8'h80); idle(3); hline(1); idle(2);

        // 52 line ends raise the interrupt; ack clears it.
        do_reset();
        hline(52); idle(2); ack_pulse();

        // Vsync-delayed interrupt with counter at 40, then at 20.
        hline(40); vsync_start(); hline(2); idle(2); ack_pulse();
        hline(20); vsync_start(); hline(2); idle(2);
        hline(52); idle(2); ack_pulse();

        // Counter reset write coinciding with the 52nd line end.
        do_reset();
        hline(51);
        step(0, 0, 0, cur_pen, 0, 1, 0);
        step(0, 0, 0, cur_pen, 0, 1, 0);
        step(0, 1, 8'h90, cur_pen, 1, 1, 0);
        idle(2); hline(1); idle(2);

        // Randomised traffic with realistic sync timing.
        hs_level = 1; hs_left = 3; vs_left = 0;
        for (int i = 0; i < 6000; i++) begin
            int w, d, ack, vs, rst;
            if (hs_left == 0) begin
                hs_level = 1 - hs_level;
                hs_left  = hs_level ? $urandom_range(2, 5) : $urandom_range(1, 3);
            end
            hs_left--;
            if (vs_left == 0 && $urandom_range(0, 299) == 0) vs_left = $urandom_range(2, 6);
            vs = (vs_left > 0) ? 0 : 1;
            if (vs_left > 0) vs_left--;
            w   = ($urandom_range(0, 7) == 0);
            d   = $urandom_range(0, 255);
            if (d[7:6] == 2'b10 && d[4] && $urandom_range(0, 3) != 0) d = d & 8'hEF;
            ack = ($urandom_range(0, 39) == 0);
            rst = ($urandom_range(0, 1499) == 0);
            step(rst, w, d, $urandom_range(0, 15), hs_level, vs, ack);
        end
        idle(3);
        @(negedge clk);
        chk("queue_drained", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete, got %0d checks expected completion", checks);
        $fatal(1);
    end

endmodule

`default_nettype wire
